// File: rtl/mult_share_pkg.sv
// ----------------------------------------------------------------------------
// mult_share_pkg
// Shared types for the multiplier-sharing arbiter.
//   state_t   : arbiter FSM states, 2-bit encoding
//   idx_width : width of a requester index for a given requester count
// ----------------------------------------------------------------------------
package mult_share_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Index width is $clog2(n). It is clamped to 1 so that a degenerate
   // count still yields a legal vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts at ptr+1 and walks
// upward, wrapping modulo NREQ, so the requester at ptr has lowest priority.
//   req     in  NREQ  request levels
//   ptr     in  IW    index of the most recently served requester
//   win_oh  out NREQ  one-hot winner (all zero when no request is high)
//   win_idx out IW    index of the winner (0 when no request is high)
// ----------------------------------------------------------------------------
module rr_pick
   import mult_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IW-1:0]   win_idx
);

   logic [IW-1:0] cand;

   // Walk from the farthest offset to the nearest; the last hit written
   // is the closest requester after ptr, which is the round-robin winner.
   always_comb begin
      win_idx = '0;
      cand    = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = IW'((int'(ptr) + i) % NREQ);
         if (req[cand]) begin
            win_idx = cand;
         end
      end
      win_oh = '0;
      if (|req) begin
         win_oh[win_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// ----------------------------------------------------------------------------
// mult_share_arbiter
// Shares one multiplier among NREQ requesters. Round-robin arbitration,
// operand latch, one-cycle start pulse, wait for done with a watchdog, and
// a one-cycle response to the winner. Zero operands bypass the multiplier,
// because its normalisation loop never terminates on zero.
//
// Handshake: a requester holds req and its operands stable until it sees
// its gnt bit; gnt means the operands were taken. The product comes back
// later as a one-cycle rsp_valid pulse on the same bit position, with
// rsp_data/rsp_err valid only during that pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   req, a_in, b_in     per-requester request level and packed operands
//   gnt, rsp_valid      one-hot accept / response pulses
//   rsp_data, rsp_err   product and timeout flag (qualified by rsp_valid)
//   busy                high whenever the FSM is not idle
//   mul_start/a/b/clr   controls to the shared multiplier
//   mul_done, mul_res   multiplier completion pulse and product
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 16,
   parameter int RW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] a_in,
   input  logic [NREQ*DW-1:0] b_in,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [RW-1:0]      rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               mul_start,
   output logic [DW-1:0]      mul_a,
   output logic [DW-1:0]      mul_b,
   output logic               mul_clr,
   input  logic               mul_done,
   input  logic [RW-1:0]      mul_res
);

   localparam int IW = idx_width(NREQ);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DW-1:0]    a_q, a_d;
   logic [DW-1:0]    b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [RW-1:0]    rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;
   logic             mul_start_q, mul_start_d;
   logic             mul_clr_q, mul_clr_d;

   logic [NREQ-1:0]  pick_oh;
   logic [IW-1:0]    pick_idx;
   logic [DW-1:0]    pick_a, pick_b;
   logic [NREQ-1:0]  win_oh;
   logic [RW-1:0]    resp_val;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (pick_oh),
      .win_idx (pick_idx)
   );

   assign pick_a = a_in[int'(pick_idx)*DW +: DW];
   assign pick_b = b_in[int'(pick_idx)*DW +: DW];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      zero_d   = zero_q;
      err_d    = err_q;
      resp_val = '0;

      case (state_q)
         S_IDLE: begin
            if (|pick_oh) begin
               idx_d = pick_idx;
               a_d   = pick_a;
               b_d   = pick_b;
               if (pick_a == '0 || pick_b == '0) begin
                  zero_d  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done is checked first so it wins over the watchdog on the
            // final counted cycle
            if (mul_done) begin
               resp_val = mul_res;
               state_d  = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            ptr_d   = idx_q;
            zero_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are computed from the next state so they land in flops.
      win_oh      = NREQ'(1) << idx_d;
      gnt_d       = (state_d == S_ISSUE || (state_d == S_RESP && zero_d)) ? win_oh : '0;
      mul_start_d = (state_d == S_ISSUE);
      rsp_valid_d = (state_d == S_RESP) ? win_oh : '0;
      rsp_data_d  = (state_d == S_RESP) ? resp_val : '0;
      rsp_err_d   = (state_d == S_RESP) && err_d;
      mul_clr_d   = (state_d == S_RESP) && err_d;
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= IW'(NREQ - 1);
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_clr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_clr_q   <= mul_clr_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign mul_start = mul_start_q;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign mul_clr   = mul_clr_q;

endmodule
